// File: rtl/wave_sequencer_pkg.sv
// Shared types for the waveform sequencer: state encoding, waveform mode codes
// and the per-segment configuration record held in the segment table.
package wave_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ARM  = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [2:0] MODE_SQUARE   = 3'b011;
  localparam logic [2:0] MODE_TRIANGLE = 3'b100;
  localparam logic [2:0] MODE_SAWTOOTH = 3'b101;

  // Duration is kept beside this record because its width is a module parameter.
  typedef struct packed {
    logic [2:0]  mode;
    logic [15:0] prescaler;
    logic [15:0] amplitude;
  } seg_cfg_t;

  function automatic logic [7:0] make_control(input logic [2:0] mode, input logic level);
    return {4'b0000, mode, level};
  endfunction

endpackage

// File: rtl/wave_seq_table.sv
// Segment table: DEPTH-entry register file, one write port, one combinational
// read port. Deliberately not reset so a reset keeps the programmed sequence.
import wave_sequencer_pkg::*;

module wave_seq_table #(
  parameter int DEPTH = 8,
  parameter int DUR_W = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  seg_cfg_t         wr_cfg,
  input  logic [DUR_W-1:0] wr_duration,
  input  logic [AW-1:0]    rd_addr,
  output seg_cfg_t         rd_cfg,
  output logic [DUR_W-1:0] rd_duration
);

  seg_cfg_t         cfg_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      cfg_mem[wr_addr] <= wr_cfg;
      dur_mem[wr_addr] <= wr_duration;
    end
  end

  assign rd_cfg      = cfg_mem[rd_addr];
  assign rd_duration = dur_mem[rd_addr];

endmodule

// File: rtl/wave_sequencer.sv
// Plays a programmed list of waveform segments, each preceded by a low gap on
// control[0]. Define WAVE_SEQ_LOOP_EN to add the 'loop' input (endless replay).
import wave_sequencer_pkg::*;

module wave_sequencer #(
  parameter int DEPTH = 8,
  parameter int DUR_W = 24,
  parameter int GAP   = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2:0]       wr_mode,
  input  logic [15:0]      wr_prescaler,
  input  logic [15:0]      wr_amplitude,
  input  logic [DUR_W-1:0] wr_duration,
  input  logic [AW:0]      num_seg,
  input  logic             start,
  input  logic             stop,
`ifdef WAVE_SEQ_LOOP_EN
  input  logic             loop,
`endif
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    seg_idx,
  output logic [7:0]       control,
  output logic [15:0]      prescaler,
  output logic [15:0]      amplitude
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [AW:0]      SEG_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      SEG_ONE  = (AW+1)'(1);

  state_t           state;
  logic [AW-1:0]    last_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [DUR_W-1:0] dur_cnt;
  seg_cfg_t         cur_cfg;
  logic [DUR_W-1:0] cur_dur;
  logic [AW:0]      seg_count;
  logic [AW:0]      seg_last_full;
  logic [DUR_W-1:0] dur_load;
  logic             loop_now;

  wave_seq_table #(
    .DEPTH(DEPTH),
    .DUR_W(DUR_W)
  ) u_table (
    .clk        (clk),
    .wr_en      (wr_en && (state == ST_IDLE)),
    .wr_addr    (wr_addr),
    .wr_cfg     ('{mode: wr_mode, prescaler: wr_prescaler, amplitude: wr_amplitude}),
    .wr_duration(wr_duration),
    .rd_addr    (seg_idx),
    .rd_cfg     (cur_cfg),
    .rd_duration(cur_dur)
  );

`ifdef WAVE_SEQ_LOOP_EN
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  assign seg_count     = (num_seg > SEG_MAX) ? SEG_MAX : num_seg;
  assign seg_last_full = seg_count - SEG_ONE;
  // A zero duration still gets one high cycle so every segment produces an edge.
  assign dur_load      = (cur_dur == '0) ? '0 : cur_dur - DUR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      seg_idx  <= '0;
      last_idx <= '0;
      gap_cnt  <= '0;
      dur_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            if (num_seg == '0) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_ARM;
              seg_idx  <= '0;
              last_idx <= seg_last_full[AW-1:0];
              gap_cnt  <= GAP_LAST;
            end
          end
        end
        ST_ARM: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (gap_cnt == '0) begin
            state   <= ST_RUN;
            dur_cnt <= dur_load;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (dur_cnt != '0) begin
            dur_cnt <= dur_cnt - DUR_W'(1);
          end else if (seg_idx != last_idx) begin
            state   <= ST_ARM;
            seg_idx <= seg_idx + AW'(1);
            gap_cnt <= GAP_LAST;
          end else if (loop_now) begin
            state   <= ST_ARM;
            seg_idx <= '0;
            gap_cnt <= GAP_LAST;
          end else begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The table cannot change while busy, so outputs read straight from it stay stable.
  always_comb begin
    busy      = (state == ST_ARM) || (state == ST_RUN);
    done      = (state == ST_DONE);
    control   = busy ? make_control(cur_cfg.mode, state == ST_RUN) : 8'h00;
    prescaler = busy ? cur_cfg.prescaler : 16'h0000;
    amplitude = busy ? cur_cfg.amplitude : 16'h0000;
  end

endmodule
